// File: rtl/serial_word_arbiter_if.sv
// Bus bundle for serial_word_arbiter.
// Carries the per-channel serial handshake (ch_valid/ch_data/ch_ready)
// and the parallel word / abort result signals.
//   master : requester side, drives serial bits and observes results
//   slave  : arbiter side, consumes serial bits and produces results
interface serial_word_arbiter_if #(
  parameter int n_ch  = 4,
  parameter int width = 8
);
  localparam int cw = $clog2(n_ch);

  logic [n_ch-1:0]  ch_valid;
  logic [n_ch-1:0]  ch_data;
  logic [n_ch-1:0]  ch_ready;
  logic             parallel_valid;
  logic [width-1:0] parallel_data;
  logic [cw-1:0]    parallel_ch;
  logic             word_abort;
  logic [cw-1:0]    abort_ch;

  modport master (
    output ch_valid,
    output ch_data,
    input  ch_ready,
    input  parallel_valid,
    input  parallel_data,
    input  parallel_ch,
    input  word_abort,
    input  abort_ch
  );

  modport slave (
    input  ch_valid,
    input  ch_data,
    output ch_ready,
    output parallel_valid,
    output parallel_data,
    output parallel_ch,
    output word_abort,
    output abort_ch
  );
endinterface

// File: rtl/serial_word_arbiter.sv
// serial_word_arbiter
// Shares one serial-to-parallel assembler among n_ch serial requesters.
// A channel is granted round-robin when the assembler is idle and keeps the
// grant until it has delivered width bits (LSB first) or has been idle for
// max_idle consecutive cycles, in which case the partial word is dropped.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : serial_word_arbiter_if.slave
//          ch_valid/ch_data in, ch_ready out (combinational),
//          parallel_valid/parallel_data/parallel_ch out (registered),
//          word_abort/abort_ch out (registered)
module serial_word_arbiter #(
  parameter int n_ch     = 4,
  parameter int width    = 8,
  parameter int max_idle = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_word_arbiter_if.slave  bus
);

  localparam int cw = $clog2(n_ch);
  localparam int bw = $clog2(width);
  localparam int iw = $clog2(max_idle + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q;
  logic [cw-1:0]    rr_ptr_q;
  logic [cw-1:0]    owner_q;
  logic [bw-1:0]    count_q;
  logic [iw-1:0]    idle_q;
  logic [width-1:0] shift_q;

  logic             parallel_valid_q;
  logic [width-1:0] parallel_data_q;
  logic [cw-1:0]    parallel_ch_q;
  logic             word_abort_q;
  logic [cw-1:0]    abort_ch_q;

  logic             win_found_s;
  logic [cw-1:0]    win_idx_s;
  logic [cw:0]      cand_s;
  logic             owner_valid_s;
  logic             owner_bit_s;
  logic             timeout_s;
  logic [n_ch-1:0]  ready_s;
  logic [width-1:0] word_d;
  logic [cw-1:0]    next_ptr_d;

  assign owner_valid_s = bus.ch_valid[owner_q];
  assign owner_bit_s   = bus.ch_data[owner_q];
  // The idle counter saturating at max_idle forces the abort even if the
  // owner's valid comes back in that very cycle.
  assign timeout_s     = (idle_q == iw'(max_idle));
  assign next_ptr_d    = (owner_q == cw'(n_ch - 1)) ? '0 : owner_q + cw'(1);

  // Round-robin search starting at rr_ptr_q, wrapping modulo n_ch.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < n_ch; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (cw+1)'(k);
      if (cand_s >= (cw+1)'(n_ch)) begin
        cand_s = cand_s - (cw+1)'(n_ch);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && bus.ch_valid[cand_s[cw-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[cw-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Word as it would look once the owner's current bit is inserted.
  always_comb begin
    word_d          = shift_q;
    word_d[count_q] = owner_bit_s;
  end

  // Consume handshake: winner in IDLE, owner only (and never on timeout) in LOCKED.
  always_comb begin
    ready_s = '0;
    if (rst) begin
      ready_s = '0;
    end else if (state_q == ST_IDLE) begin
      if (win_found_s) begin
        ready_s[win_idx_s] = 1'b1;
      end else begin
        ready_s = '0;
      end
    end else begin
      if (timeout_s) begin
        ready_s = '0;
      end else begin
        ready_s[owner_q] = owner_valid_s;
      end
    end
  end

  // Arbitration FSM, word assembly and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      rr_ptr_q         <= '0;
      owner_q          <= '0;
      count_q          <= '0;
      idle_q           <= '0;
      shift_q          <= '0;
      parallel_valid_q <= 1'b0;
      parallel_data_q  <= '0;
      parallel_ch_q    <= '0;
      word_abort_q     <= 1'b0;
      abort_ch_q       <= '0;
    end else begin
      parallel_valid_q <= 1'b0;
      word_abort_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found_s) begin
            owner_q <= win_idx_s;
            shift_q <= {{(width-1){1'b0}}, bus.ch_data[win_idx_s]};
            count_q <= bw'(1);
            idle_q  <= '0;
            state_q <= ST_LOCKED;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (timeout_s) begin
            word_abort_q <= 1'b1;
            abort_ch_q   <= owner_q;
            rr_ptr_q     <= next_ptr_d;
            count_q      <= '0;
            idle_q       <= '0;
            shift_q      <= '0;
            state_q      <= ST_IDLE;
          end else if (owner_valid_s) begin
            idle_q <= '0;
            if (count_q == bw'(width - 1)) begin
              parallel_valid_q <= 1'b1;
              parallel_data_q  <= word_d;
              parallel_ch_q    <= owner_q;
              rr_ptr_q         <= next_ptr_d;
              count_q          <= '0;
              shift_q          <= '0;
              state_q          <= ST_IDLE;
            end else begin
              shift_q <= word_d;
              count_q <= count_q + bw'(1);
            end
          end else begin
            idle_q <= idle_q + iw'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ch_ready       = ready_s;
  assign bus.parallel_valid = parallel_valid_q;
  assign bus.parallel_data  = parallel_data_q;
  assign bus.parallel_ch    = parallel_ch_q;
  assign bus.word_abort     = word_abort_q;
  assign bus.abort_ch       = abort_ch_q;

endmodule

// File: tb/tb_serial_word_arbiter.sv
// Directed testbench for serial_word_arbiter (n_ch=4, width=8, max_idle=15).
// Table-driven vectors cover reset, single-channel assembly, round-robin and
// grant locking; hand-written sequences cover stall, timeout and mid-word reset.
module tb_serial_word_arbiter;

  logic clk;
  logic rst;

  serial_word_arbiter_if #(.n_ch(4), .width(8)) bus ();

  serial_word_arbiter #(.n_ch(4), .width(8), .max_idle(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int pv_count;
  int ab_count;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] dat;
    logic [3:0] exp_rdy;
    logic       chk_out;
    logic       exp_pv;
    logic [7:0] exp_pd;
    logic [1:0] exp_pch;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] hold_pd;
  logic [1:0] hold_pch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic apply(input logic r, input logic [3:0] v, input logic [3:0] d);
    @(posedge clk);
    #1;
    rst          = r;
    bus.ch_valid = v;
    bus.ch_data  = d;
    @(negedge clk);
  endtask

  task automatic add_rst(input logic [3:0] v);
    vec_t e;
    e = '{rst: 1'b1, vld: v, dat: 4'h0, exp_rdy: 4'h0, chk_out: 1'b0,
          exp_pv: 1'b0, exp_pd: 8'h00, exp_pch: 2'd0};
    vecs.push_back(e);
    e.chk_out = 1'b1;
    vecs.push_back(e);
    hold_pd  = 8'h00;
    hold_pch = 2'd0;
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] d, input logic [3:0] er);
    vec_t e;
    e = '{rst: 1'b0, vld: v, dat: d, exp_rdy: er, chk_out: 1'b1,
          exp_pv: 1'b0, exp_pd: hold_pd, exp_pch: hold_pch};
    vecs.push_back(e);
  endtask

  task automatic add_word(input logic [3:0] v, input logic [3:0] d, input logic [3:0] er,
                          input logic [7:0] pd, input logic [1:0] pch);
    vec_t e;
    hold_pd  = pd;
    hold_pch = pch;
    e = '{rst: 1'b0, vld: v, dat: d, exp_rdy: er, chk_out: 1'b1,
          exp_pv: 1'b1, exp_pd: pd, exp_pch: pch};
    vecs.push_back(e);
  endtask

  // Pulse monitor: counts pulses and checks they are never simultaneous.
  always @(negedge clk) begin
    #1;
    if (bus.parallel_valid || bus.word_abort) begin
      check("pulse_exclusive", {31'd0, bus.parallel_valid && bus.word_abort}, 32'd0);
    end
    if (bus.parallel_valid) pv_count++;
    if (bus.word_abort) ab_count++;
  end

  initial begin
    logic [7:0] bits;
    int         pv0;
    int         ab0;

    checks       = 0;
    errors       = 0;
    pv_count     = 0;
    ab_count     = 0;
    rst          = 1'b1;
    bus.ch_valid = 4'h0;
    bus.ch_data  = 4'h0;
    hold_pd      = 8'h00;
    hold_pch     = 2'd0;

    // Single channel: ch1 sends 1,0,1,1,0,0,1,0 -> 8'h4D.
    add_rst(4'b1111);
    bits = 8'h4D;
    for (int k = 0; k < 8; k++) add(4'b0010, {2'b00, bits[k], 1'b0}, 4'b0010);
    add_word(4'b0000, 4'b0000, 4'b0000, 8'h4D, 2'd1);
    add(4'b0000, 4'b0000, 4'b0000);

    // Round-robin: ch0 streams ones, ch2 streams zeros, no bubble between words.
    add_rst(4'b0000);
    for (int k = 0; k < 8; k++) add(4'b0101, 4'b0001, 4'b0001);
    add_word(4'b0101, 4'b0001, 4'b0100, 8'hFF, 2'd0);
    for (int k = 1; k < 8; k++) add(4'b0101, 4'b0001, 4'b0100);
    add_word(4'b0101, 4'b0001, 4'b0001, 8'h00, 2'd2);
    for (int k = 1; k < 8; k++) add(4'b0101, 4'b0001, 4'b0001);
    add_word(4'b0101, 4'b0001, 4'b0100, 8'hFF, 2'd0);

    // Lock: ch3 owns the word, ch0 requests mid-word, ch0 wins next via wrap.
    add_rst(4'b0000);
    add(4'b1000, 4'b1000, 4'b1000);
    add(4'b1000, 4'b1000, 4'b1000);
    for (int k = 2; k < 8; k++) add(4'b1001, 4'b1000, 4'b1000);
    add_word(4'b1001, 4'b1000, 4'b0001, 8'hFF, 2'd3);
    for (int k = 1; k < 8; k++) add(4'b1001, 4'b1000, 4'b0001);
    add_word(4'b1001, 4'b1000, 4'b1000, 8'h00, 2'd0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].vld, vecs[i].dat);
      check($sformatf("tbl%0d_ready", i), {28'd0, bus.ch_ready}, {28'd0, vecs[i].exp_rdy});
      if (vecs[i].chk_out) begin
        check($sformatf("tbl%0d_pvalid", i), {31'd0, bus.parallel_valid}, {31'd0, vecs[i].exp_pv});
        check($sformatf("tbl%0d_pdata", i), {24'd0, bus.parallel_data}, {24'd0, vecs[i].exp_pd});
        check($sformatf("tbl%0d_pch", i), {30'd0, bus.parallel_ch}, {30'd0, vecs[i].exp_pch});
        check($sformatf("tbl%0d_abort", i), {31'd0, bus.word_abort}, 32'd0);
      end
    end

    // Stall within limit: ch1 idles 14 cycles after 4 bits, word 8'hA5 completes.
    apply(1'b1, 4'b0000, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000);
    pv0  = pv_count;
    ab0  = ab_count;
    bits = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 4'b0010, {2'b00, bits[k], 1'b0});
      check("stall_ready_a", {28'd0, bus.ch_ready}, 32'h2);
    end
    for (int k = 0; k < 14; k++) begin
      apply(1'b0, 4'b0000, 4'b0000);
      check("stall_ready_idle", {28'd0, bus.ch_ready}, 32'h0);
    end
    for (int k = 4; k < 8; k++) begin
      apply(1'b0, 4'b0010, {2'b00, bits[k], 1'b0});
      check("stall_ready_b", {28'd0, bus.ch_ready}, 32'h2);
    end
    apply(1'b0, 4'b0000, 4'b0000);
    check("stall_pvalid", {31'd0, bus.parallel_valid}, 32'd1);
    check("stall_pdata", {24'd0, bus.parallel_data}, 32'hA5);
    check("stall_pch", {30'd0, bus.parallel_ch}, 32'd1);
    apply(1'b0, 4'b0000, 4'b0000);
    check("stall_no_abort", ab_count - ab0, 32'd0);
    check("stall_one_word", pv_count - pv0, 32'd1);

    // Timeout: ch2 idles 15 cycles after 3 bits; returning valid is refused.
    apply(1'b1, 4'b0000, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000);
    pv0 = pv_count;
    ab0 = ab_count;
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 4'b0100, 4'b0100);
      check("tmo_ready_bits", {28'd0, bus.ch_ready}, 32'h4);
    end
    for (int k = 0; k < 15; k++) begin
      apply(1'b0, 4'b0000, 4'b0000);
      check("tmo_idle_abort", {31'd0, bus.word_abort}, 32'd0);
    end
    apply(1'b0, 4'b0110, 4'b0110);
    check("tmo_ready_refused", {28'd0, bus.ch_ready}, 32'h0);
    check("tmo_abort_early", {31'd0, bus.word_abort}, 32'd0);
    apply(1'b0, 4'b0110, 4'b0110);
    check("tmo_abort", {31'd0, bus.word_abort}, 32'd1);
    check("tmo_abort_ch", {30'd0, bus.abort_ch}, 32'd2);
    check("tmo_pvalid", {31'd0, bus.parallel_valid}, 32'd0);
    check("tmo_next_grant", {28'd0, bus.ch_ready}, 32'h2);
    apply(1'b0, 4'b0000, 4'b0000);
    check("tmo_abort_pulse", {31'd0, bus.word_abort}, 32'd0);
    apply(1'b0, 4'b0000, 4'b0000);
    check("tmo_abort_count", ab_count - ab0, 32'd1);
    check("tmo_no_word", pv_count - pv0, 32'd0);

    // Reset mid-word: ch2 partial word dropped; ch1 granted first afterwards.
    apply(1'b1, 4'b0000, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000);
    pv0 = pv_count;
    ab0 = ab_count;
    for (int k = 0; k < 5; k++) apply(1'b0, 4'b0100, 4'b0100);
    apply(1'b1, 4'b0100, 4'b0100);
    check("rstmid_ready_rst", {28'd0, bus.ch_ready}, 32'h0);
    apply(1'b0, 4'b0110, 4'b0110);
    check("rstmid_grant_ch1", {28'd0, bus.ch_ready}, 32'h2);
    check("rstmid_pvalid", {31'd0, bus.parallel_valid}, 32'd0);
    for (int k = 1; k < 8; k++) apply(1'b0, 4'b0110, 4'b0110);
    apply(1'b0, 4'b0110, 4'b0110);
    check("rstmid_word_pvalid", {31'd0, bus.parallel_valid}, 32'd1);
    check("rstmid_word_pdata", {24'd0, bus.parallel_data}, 32'hFF);
    check("rstmid_word_pch", {30'd0, bus.parallel_ch}, 32'd1);
    check("rstmid_next_ch2", {28'd0, bus.ch_ready}, 32'h4);
    apply(1'b0, 4'b0000, 4'b0000);
    check("rstmid_word_count", pv_count - pv0, 32'd1);
    check("rstmid_abort_count", ab_count - ab0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_arbiter.md
Name: serial_word_arbiter

Overview:
- Shares one serial-to-parallel word assembler among n_ch serial requesters.
- Grants one channel at a time and locks that grant for a full width-bit word.
- Deassembles nothing: it shifts the granted channel's bits in and emits a parallel word tagged with the source channel.
- Round-robin between words; aborts a stalled word after a programmable idle timeout.

Parameters:
- n_ch, 4, number of serial requesters (2..16)
- width, 8, bits per word (>= 2)
- max_idle, 15, consecutive idle cycles of the locked owner before the word is aborted (>= 1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ch_valid  in  n_ch  per-channel serial bit valid
- ch_data  in  n_ch  per-channel serial bit
- ch_ready  out  n_ch  combinational; ch_ready[i]=1 means the bit of channel i is consumed this cycle
- parallel_valid  out  1  one-cycle pulse, word complete
- parallel_data  out  width  assembled word; bit k = k-th accepted bit (LSB first)
- parallel_ch  out  $clog2(n_ch)  source channel of parallel_data
- word_abort  out  1  one-cycle pulse, locked word dropped on timeout
- abort_ch  out  $clog2(n_ch)  channel whose word was aborted

Behaviour:
- Reset (sync): state=IDLE, rr_ptr=0, bit count=0, idle count=0, shift register=0. All outputs are 0; ch_ready is 0 in the reset cycle.
- States are IDLE and LOCKED. owner is a $clog2(n_ch) register.
- IDLE:
  - Winner = first i with ch_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping mod n_ch.
  - ch_ready[winner]=1 in the same cycle. That bit is stored at position 0, count=1, owner=winner, next state LOCKED.
  - No valid: stay IDLE, ch_ready=0.
- LOCKED:
  - ch_ready = onehot(owner) & ch_valid. Other channels see ch_ready=0 regardless of ch_valid.
  - Accepted bit is stored at position count, count++, idle count cleared.
  - Owner ch_valid=0: idle count++, word held, grant held.
- Word complete: the cycle the width-th bit is accepted:
  - Next cycle: parallel_valid=1, parallel_data=word, parallel_ch=owner.
  - state=IDLE, rr_ptr=(owner+1) mod n_ch, count=0.
  - A new arbitration may accept a bit in that same next cycle, so back-to-back words from different channels have no bubble.
- Timeout: in LOCKED, when idle count reaches max_idle:
  - Next cycle: word_abort=1, abort_ch=owner, partial bits discarded, state=IDLE, rr_ptr=(owner+1) mod n_ch.
  - parallel_valid is not asserted for the aborted word.
  - The owner's valid returning in the same cycle the count reaches max_idle is still counted as idle. The abort wins and that bit is not accepted (ch_ready=0).
- Outputs are registered:
  - parallel_valid and word_abort are high exactly one cycle and never simultaneously.
  - parallel_data and parallel_ch hold their last value between pulses.
- Wrap: rr_ptr wraps n_ch-1 -> 0. A single requester repeatedly granted is legal; it gets back-to-back words.
- Reset mid-word: partial word discarded with no pulse; arbitration restarts at channel 0.
- Latency: last bit accepted at cycle T -> parallel_valid at T+1. First bit of a word is accepted the cycle valid is seen in IDLE.

Test Plan:
- Single channel: ch1 sends 8 bits 1,0,1,1,0,0,1,0 on consecutive cycles -> parallel_valid pulse 1 cycle after 8th bit, parallel_data=8'h4D, parallel_ch=1, ch_ready[0,2,3]=0 throughout.
- Round-robin: ch0 and ch2 valid continuously after reset with data 8'hFF and 8'h00 streams -> words alternate ch0, ch2, ch0, with data FF, 00, FF, no idle cycle between words.
- Lock: ch3 granted; ch0 asserts valid mid-word -> ch_ready[0]=0 until ch3's 8th bit; next word is ch0 (rr_ptr wrapped 3->0).
- Stall within limit: owner drops valid for 14 cycles at bit 4, then resumes -> correct word, no word_abort.
- Timeout: owner drops valid for 15 cycles after 3 bits -> word_abort pulse, abort_ch=owner, no parallel_valid; next requester is granted in following arbitration.
- Reset mid-word: rst for 1 cycle after 5 bits of ch2 -> no output pulse; ch1 and ch2 both valid afterwards -> ch1 granted first (rr_ptr=0 search order).
